// File: rtl/sa_operand_feeder.sv
// Operand feeder for the NxN systolic array: buffers one A/B tile, then streams it with diagonal skew.
// Optional macro SA_FEED_TRANSPOSE_EN: in_b beats carry rows of B instead of columns.
module sa_operand_feeder #(
    parameter int unsigned N  = 4,
    parameter int unsigned DW = 8
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [N*DW-1:0] in_a,
    input  logic [N*DW-1:0] in_b,
    output logic [N*DW-1:0] a_out,
    output logic [N*DW-1:0] b_out,
    output logic [N-1:0]    a_vld,
    output logic [N-1:0]    b_vld,
    output logic            acc_clr,
    output logic            done,
    output logic            busy
);

    localparam int unsigned BW = (N > 1) ? $clog2(N) : 1;
    localparam int unsigned SW = $clog2(3 * N);
    localparam logic [BW-1:0] LAST_BEAT  = BW'(N - 1);
    localparam logic [SW-1:0] FEED_END   = SW'(2 * N - 2);
    localparam logic [SW-1:0] FLUSH_END  = SW'(3 * N - 2);

    typedef enum logic [1:0] {
        LOAD,
        FEED,
        FLUSH
    } state_t;

    state_t          state;
    logic [BW-1:0]   beat_cnt;
    logic [SW-1:0]   step_cnt;
    logic [DW-1:0]   a_buf [N][N];   // a_buf[row][col] of A
    logic [DW-1:0]   b_buf [N][N];   // b_buf[row][col] of B

    logic            fire_c;
    logic            last_beat_c;
    logic            run_nxt_c;
    logic [SW-1:0]   step_nxt_c;
    logic [N*DW-1:0] a_lane_c;
    logic [N*DW-1:0] b_lane_c;
    logic [N-1:0]    a_vld_lane_c;
    logic [N-1:0]    b_vld_lane_c;

    // Handshake and the step about to be presented after the next edge.
    always_comb begin
        fire_c      = in_valid && in_ready;
        last_beat_c = fire_c && (beat_cnt == LAST_BEAT);
        step_nxt_c  = (state == LOAD) ? '0 : step_cnt + SW'(1);
        run_nxt_c   = last_beat_c || (state == FEED) ||
                      ((state == FLUSH) && (step_cnt != FLUSH_END));
    end

    // Skewed lane values for step_nxt_c; steps past 2N-2 select nothing, so FLUSH is all-zero.
    // Step 0 only needs beat 0, which is already stored when the last beat lands (N >= 2).
    always_comb begin
        a_lane_c     = '0;
        b_lane_c     = '0;
        a_vld_lane_c = '0;
        b_vld_lane_c = '0;
        for (int i = 0; i < int'(N); i++) begin
            if (run_nxt_c && (int'(step_nxt_c) >= i) && (int'(step_nxt_c) < i + int'(N))) begin
                a_lane_c[DW*i +: DW] = a_buf[i][BW'(int'(step_nxt_c) - i)];
                b_lane_c[DW*i +: DW] = b_buf[BW'(int'(step_nxt_c) - i)][i];
                a_vld_lane_c[i]      = 1'b1;
                b_vld_lane_c[i]      = 1'b1;
            end
        end
    end

    // Control FSM, tile buffers and registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= LOAD;
            beat_cnt <= '0;
            step_cnt <= '0;
            for (int r = 0; r < int'(N); r++) begin
                for (int c = 0; c < int'(N); c++) begin
                    a_buf[r][c] <= '0;
                    b_buf[r][c] <= '0;
                end
            end
            a_out    <= '0;
            b_out    <= '0;
            a_vld    <= '0;
            b_vld    <= '0;
            acc_clr  <= 1'b0;
            done     <= 1'b0;
            busy     <= 1'b0;
            in_ready <= 1'b0;
        end else begin
            a_out   <= a_lane_c;
            b_out   <= b_lane_c;
            a_vld   <= a_vld_lane_c;
            b_vld   <= b_vld_lane_c;
            acc_clr <= last_beat_c;
            done    <= 1'b0;
            case (state)
                LOAD: begin
                    in_ready <= 1'b1;
                    busy     <= 1'b0;
                    if (fire_c) begin
                        for (int i = 0; i < int'(N); i++) begin
                            a_buf[beat_cnt][i] <= in_a[DW*i +: DW];
`ifdef SA_FEED_TRANSPOSE_EN
                            b_buf[beat_cnt][i] <= in_b[DW*i +: DW];
`else
                            b_buf[i][beat_cnt] <= in_b[DW*i +: DW];
`endif
                        end
                        if (last_beat_c) begin
                            state    <= FEED;
                            beat_cnt <= '0;
                            step_cnt <= '0;
                            in_ready <= 1'b0;
                            busy     <= 1'b1;
                        end else begin
                            beat_cnt <= beat_cnt + BW'(1);
                        end
                    end
                end
                FEED: begin
                    in_ready <= 1'b0;
                    busy     <= 1'b1;
                    step_cnt <= step_nxt_c;
                    if (step_cnt == FEED_END) begin
                        state <= FLUSH;
                    end
                end
                FLUSH: begin
                    if (step_cnt == FLUSH_END) begin
                        state    <= LOAD;
                        step_cnt <= '0;
                        done     <= 1'b1;
                        in_ready <= 1'b1;
                        busy     <= 1'b0;
                    end else begin
                        step_cnt <= step_nxt_c;
                    end
                end
                default: begin
                    state <= LOAD;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sa_operand_feeder.sv
// Self-checking bench for sa_operand_feeder: directed step table plus randomized tiles vs. a matrix model.
module tb_sa_operand_feeder;

    localparam int unsigned N  = 4;
    localparam int unsigned DW = 8;
    localparam int unsigned W  = N * DW;

    logic         clk = 1'b0;
    logic         reset;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_a;
    logic [W-1:0] in_b;
    logic [W-1:0] a_out;
    logic [W-1:0] b_out;
    logic [N-1:0] a_vld;
    logic [N-1:0] b_vld;
    logic         acc_clr;
    logic         done;
    logic         busy;

    always #5 clk = ~clk;

    sa_operand_feeder #(.N(N), .DW(DW)) dut (
        .clk      (clk),
        .reset    (reset),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_a     (in_a),
        .in_b     (in_b),
        .a_out    (a_out),
        .b_out    (b_out),
        .a_vld    (a_vld),
        .b_vld    (b_vld),
        .acc_clr  (acc_clr),
        .done     (done),
        .busy     (busy)
    );

    typedef struct {
        logic [W-1:0] a;
        logic [N-1:0] av;
        logic [W-1:0] b;
        logic [N-1:0] bv;
        logic [3:0]   flags;   // {in_ready, busy, acc_clr, done}
    } vec_t;

    vec_t tbl [12];

    int checks   = 0;
    int failures = 0;
    int done_cnt = 0;

    // Reference model: matrices as received plus cycles elapsed since the last beat.
    bit           m_run;
    bit           m_done;
    bit           m_rdy0;
    int           m_t;
    int           m_beats;
    logic [DW-1:0] ma [N][N];
    logic [DW-1:0] mb [N][N];

    // Tile under test as plain matrices A[row][col], B[row][col].
    int ta  [N][N];
    int tbm [N][N];

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_run   = 1'b0;
        m_done  = 1'b0;
        m_rdy0  = 1'b1;
        m_t     = 0;
        m_beats = 0;
    endtask

    task automatic model_step(input bit v, input logic [W-1:0] a, input logic [W-1:0] b);
        if (!m_run) begin
            m_done = 1'b0;
            if (v && !m_rdy0) begin
                for (int i = 0; i < int'(N); i++) begin
                    ma[m_beats][i] = a[DW*i +: DW];
`ifdef SA_FEED_TRANSPOSE_EN
                    mb[m_beats][i] = b[DW*i +: DW];
`else
                    mb[i][m_beats] = b[DW*i +: DW];
`endif
                end
                m_beats++;
                if (m_beats == int'(N)) begin
                    m_beats = 0;
                    m_run   = 1'b1;
                    m_t     = 0;
                end
            end
        end else if (m_t == 3 * int'(N) - 2) begin
            m_run  = 1'b0;
            m_done = 1'b1;
        end else begin
            m_t++;
        end
        m_rdy0 = 1'b0;
    endtask

    task automatic model_check();
        logic [W-1:0] ea;
        logic [W-1:0] eb;
        logic [N-1:0] eav;
        logic [N-1:0] ebv;
        int d;
        ea = '0; eb = '0; eav = '0; ebv = '0;
        if (m_run) begin
            for (int i = 0; i < int'(N); i++) begin
                d = m_t - i;
                if (d >= 0 && d < int'(N)) begin
                    ea[DW*i +: DW] = ma[i][d];
                    eb[DW*i +: DW] = mb[d][i];
                    eav[i] = 1'b1;
                    ebv[i] = 1'b1;
                end
            end
        end
        chk("a_out", a_out, ea);
        chk("b_out", b_out, eb);
        chk("a_vld", W'(a_vld), W'(eav));
        chk("b_vld", W'(b_vld), W'(ebv));
        chk("flags{rdy,busy,clr,done}", W'({in_ready, busy, acc_clr, done}),
            W'({!m_run && !m_rdy0, m_run, m_run && (m_t == 0), m_done}));
        if (done) done_cnt++;
    endtask

    // One clock: drive at negedge, update model at posedge, check at next negedge.
    task automatic cycle(input bit v, input logic [W-1:0] a, input logic [W-1:0] b);
        in_valid = v;
        in_a     = a;
        in_b     = b;
        @(posedge clk);
        model_step(v, a, b);
        @(negedge clk);
        model_check();
    endtask

    function automatic logic [W-1:0] beat_a(input int k);
        logic [W-1:0] r;
        for (int i = 0; i < int'(N); i++) r[DW*i +: DW] = DW'(ta[k][i]);
        return r;
    endfunction

    function automatic logic [W-1:0] beat_b(input int k);
        logic [W-1:0] r;
        for (int i = 0; i < int'(N); i++) begin
`ifdef SA_FEED_TRANSPOSE_EN
            r[DW*i +: DW] = DW'(tbm[k][i]);
`else
            r[DW*i +: DW] = DW'(tbm[i][k]);
`endif
        end
        return r;
    endfunction

    function automatic logic [W-1:0] rnd();
        return W'($urandom);
    endfunction

    task automatic fill_pattern();
        for (int r = 0; r < int'(N); r++)
            for (int c = 0; c < int'(N); c++) begin
                ta[r][c]  = 16 * r + c;
                tbm[r][c] = 16 * r + c;
            end
    endtask

    task automatic fill_random();
        for (int r = 0; r < int'(N); r++)
            for (int c = 0; c < int'(N); c++) begin
                ta[r][c]  = int'($urandom_range(255, 0));
                tbm[r][c] = int'($urandom_range(255, 0));
            end
    endtask

    task automatic load_tile(input int max_gap);
        for (int k = 0; k < int'(N); k++) begin
            repeat ($urandom_range(max_gap, 0)) cycle(1'b0, rnd(), rnd());
            cycle(1'b1, beat_a(k), beat_b(k));
        end
    endtask

    task automatic tbl_check(input int k);
        chk($sformatf("tbl%0d_a_out", k), a_out, tbl[k].a);
        chk($sformatf("tbl%0d_a_vld", k), W'(a_vld), W'(tbl[k].av));
        chk($sformatf("tbl%0d_b_out", k), b_out, tbl[k].b);
        chk($sformatf("tbl%0d_b_vld", k), W'(b_vld), W'(tbl[k].bv));
        chk($sformatf("tbl%0d_flags", k), W'({in_ready, busy, acc_clr, done}), W'(tbl[k].flags));
    endtask

    // Called at the negedge showing step 0; walks steps 0..10 and the done cycle.
    task automatic run_tbl(input bit hold_valid);
        done_cnt = 0;
        tbl_check(0);
        for (int k = 1; k < 12; k++) begin
            cycle(hold_valid, rnd(), rnd());
            tbl_check(k);
        end
        chk("done_pulse_count", W'(done_cnt), W'(1));
    endtask

    initial begin
        tbl[0]  = '{a: 32'h00000000, av: 4'b0001, b: 32'h00000000, bv: 4'b0001, flags: 4'b0110};
        tbl[1]  = '{a: 32'h00001001, av: 4'b0011, b: 32'h00000110, bv: 4'b0011, flags: 4'b0100};
        tbl[2]  = '{a: 32'h00201102, av: 4'b0111, b: 32'h00021120, bv: 4'b0111, flags: 4'b0100};
        tbl[3]  = '{a: 32'h30211203, av: 4'b1111, b: 32'h03122130, bv: 4'b1111, flags: 4'b0100};
        tbl[4]  = '{a: 32'h31221300, av: 4'b1110, b: 32'h13223100, bv: 4'b1110, flags: 4'b0100};
        tbl[5]  = '{a: 32'h32230000, av: 4'b1100, b: 32'h23320000, bv: 4'b1100, flags: 4'b0100};
        tbl[6]  = '{a: 32'h33000000, av: 4'b1000, b: 32'h33000000, bv: 4'b1000, flags: 4'b0100};
        for (int k = 7; k < 11; k++)
            tbl[k] = '{a: '0, av: '0, b: '0, bv: '0, flags: 4'b0100};
        tbl[11] = '{a: '0, av: '0, b: '0, bv: '0, flags: 4'b1001};

        reset = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0;
        model_reset();
        #2;
        chk("reset_outputs", a_out | b_out, '0);
        chk("reset_flags", W'({in_ready, busy, acc_clr, done, a_vld, b_vld}), '0);
        @(posedge clk); #1 reset = 1'b0;
        @(negedge clk);
        cycle(1'b0, '0, '0);
        cycle(1'b0, '0, '0);

        // Directed pattern tile, back-to-back beats.
        fill_pattern();
        load_tile(0);
        run_tbl(1'b0);

        // Sparse valid pattern: 4 beats across 9 cycles.
        begin
            bit pat [9] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
            int k = 0;
            for (int c = 0; c < 9; c++) begin
                if (pat[c]) begin
                    cycle(1'b1, beat_a(k), beat_b(k));
                    k++;
                end else begin
                    cycle(1'b0, rnd(), rnd());
                end
            end
        end
        run_tbl(1'b0);

        // in_valid held high through FEED/FLUSH, next tile starts in the done cycle.
        fill_pattern();
        load_tile(0);
        run_tbl(1'b1);
        fill_random();
        load_tile(0);
        repeat (12) cycle(1'b0, rnd(), rnd());

        // Reset at step 3.
        fill_pattern();
        load_tile(0);
        repeat (3) cycle(1'b1, rnd(), rnd());
        tbl_check(3);
        #1 reset = 1'b1;
        #1;
        chk("midrst_outputs", a_out | b_out, '0);
        chk("midrst_flags", W'({in_ready, busy, acc_clr, done, a_vld, b_vld}), '0);
        model_reset();
        @(negedge clk);
        reset = 1'b0;
        done_cnt = 0;
        repeat (14) cycle(1'b0, rnd(), rnd());
        chk("midrst_no_done", W'(done_cnt), '0);
        fill_pattern();
        load_tile(0);
        run_tbl(1'b0);

        // Randomized tiles with random gaps.
        for (int r = 0; r < 6; r++) begin
            fill_random();
            load_tile(3);
            repeat (12 + $urandom_range(2, 0)) cycle(1'b0, rnd(), rnd());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
